mc_control: RTL and testbench

Multi-cycle sequencer for the RISC-V datapath. Decodes the 7-bit opcode and steps the shared ALU, register file, PC and unified memory through fetch, decode, execute, memory and writeback states. It drives the same control semantics as the single-cycle control unit (ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp), spread over cycles. It also stalls on a memory ready handshake and counts retired instructions.

---
 rtl/mc_control.sv | 150 +++++++++++++++
 tb/tb_mc_control.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mc_control.sv
// Multi-cycle RISC-V control sequencer: steps fetch/decode/execute/memory/writeback.
// Outputs are combinational from state; mem_ready stalls FETCH/MEM_RD/MEM_WR.
module mc_control (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  opcode,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        pc_write,
   output logic        pc_src,
   output logic        ir_write,
   output logic [1:0]  alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  alu_op,
   output logic        mem_read,
   output logic        mem_write,
   output logic        i_or_d,
   output logic        mem_to_reg,
   output logic        reg_write,
   output logic        illegal,
   output logic [3:0]  state,
   output logic [15:0] retired
);

   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_EXEC_R   = 4'd2;
   localparam logic [3:0] S_EXEC_I   = 4'd3;
   localparam logic [3:0] S_MEM_ADDR = 4'd4;
   localparam logic [3:0] S_MEM_RD   = 4'd5;
   localparam logic [3:0] S_MEM_WR   = 4'd6;
   localparam logic [3:0] S_WB_ALU   = 4'd7;
   localparam logic [3:0] S_WB_MEM   = 4'd8;
   localparam logic [3:0] S_BRANCH   = 4'd9;
   localparam logic [3:0] S_ILLEGAL  = 4'd10;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   logic [3:0]  state_q;
   logic [3:0]  state_d;
   logic        illegal_q;
   logic [15:0] retired_q;
   logic        retire;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
         retired_q <= 16'd0;
      end else begin
         state_q <= state_d;
         if (state_q == S_ILLEGAL)
            illegal_q <= 1'b1;
         if (retire)
            retired_q <= retired_q + 16'd1;
      end
   end

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_R:               state_d = S_EXEC_R;
               OP_I:               state_d = S_EXEC_I;
               OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
               OP_BRANCH:          state_d = S_BRANCH;
               default:            state_d = S_ILLEGAL;
            endcase
         end
         S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
         S_MEM_ADDR: state_d = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   state_d = mem_ready ? S_WB_MEM : S_MEM_RD;
         S_MEM_WR:   state_d = mem_ready ? S_FETCH : S_MEM_WR;
         default:    state_d = S_FETCH;
      endcase
   end

   always_comb begin
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      ir_write   = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      i_or_d     = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         // ALU forms PC-relative branch target while the opcode is decoded
         S_DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
         end
         S_EXEC_R: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b10;
         end
         S_EXEC_I: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b10;
            alu_op    = 2'b10;
         end
         S_MEM_ADDR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b10;
         end
         S_MEM_RD: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
         end
         S_MEM_WR: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
         end
         S_WB_ALU: reg_write = 1'b1;
         S_WB_MEM: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b01;
            pc_src    = 1'b1;
            pc_write  = zero;
         end
         default: ;
      endcase
   end

   assign retire  = (state_q == S_WB_ALU) || (state_q == S_WB_MEM) || (state_q == S_BRANCH) ||
                    ((state_q == S_MEM_WR) && mem_ready);
   assign illegal = illegal_q || (state_q == S_ILLEGAL);
   assign state   = state_q;
   assign retired = retired_q;

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: per-cycle expectations queued by the driver, checked at negedge.
module tb_mc_control;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [6:0]  opcode = 7'd0;
   logic        zero = 1'b0;
   logic        mem_ready = 1'b0;
   logic        pc_write, pc_src, ir_write;
   logic [1:0]  alu_src_a, alu_src_b, alu_op;
   logic        mem_read, mem_write, i_or_d, mem_to_reg, reg_write, illegal;
   logic [3:0]  state;
   logic [15:0] retired;

   mc_control dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
      .mem_to_reg(mem_to_reg), .reg_write(reg_write), .illegal(illegal),
      .state(state), .retired(retired)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  st;
      logic [13:0] ctl;
      logic [15:0] ret;
      logic        ill;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_err = 0;
   logic [15:0] exp_ret = 16'd0;
   logic        exp_ill = 1'b0;
   logic [13:0] obs_ctl;

   assign obs_ctl = {pc_write, pc_src, ir_write, alu_src_a, alu_src_b, alu_op,
                     mem_read, mem_write, i_or_d, mem_to_reg, reg_write};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, expv, $time);
      end
   endtask

   // Control table: {pc_write,pc_src,ir_write,a[1:0],b[1:0],op[1:0],mrd,mwr,iord,m2r,rw}
   function automatic logic [13:0] exp_ctl(input logic [3:0] st, input logic mr, input logic z);
      case (st)
         4'd0:    return {mr, 1'b0, mr, 2'b00, 2'b01, 2'b00, 5'b10000};
         4'd1:    return {3'b000, 2'b01, 2'b10, 2'b00, 5'b00000};
         4'd2:    return {3'b000, 2'b10, 2'b00, 2'b10, 5'b00000};
         4'd3:    return {3'b000, 2'b10, 2'b10, 2'b10, 5'b00000};
         4'd4:    return {3'b000, 2'b10, 2'b10, 2'b00, 5'b00000};
         4'd5:    return {3'b000, 2'b00, 2'b00, 2'b00, 5'b10100};
         4'd6:    return {3'b000, 2'b00, 2'b00, 2'b00, 5'b01100};
         4'd7:    return {3'b000, 2'b00, 2'b00, 2'b00, 5'b00001};
         4'd8:    return {3'b000, 2'b00, 2'b00, 2'b00, 5'b00011};
         4'd9:    return {z, 1'b1, 1'b0, 2'b10, 2'b00, 2'b01, 5'b00000};
         default: return 14'd0;
      endcase
   endfunction

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk($sformatf("state@%0d", e.st), {28'd0, state}, {28'd0, e.st});
         chk($sformatf("ctl@%0d", e.st), {18'd0, obs_ctl}, {18'd0, e.ctl});
         chk($sformatf("retired@%0d", e.st), {16'd0, retired}, {16'd0, e.ret});
         chk($sformatf("illegal@%0d", e.st), {31'd0, illegal}, {31'd0, e.ill});
      end
   end

   // Drive one cycle expected to be spent in state st, then advance past the next edge.
   task automatic cyc(input logic [3:0] st, input logic mr, input logic z);
      mem_ready = mr;
      zero = z;
      sb.push_back('{st: st, ctl: exp_ctl(st, mr, z), ret: exp_ret,
                     ill: exp_ill || (st == 4'd10)});
      if (st == 4'd7 || st == 4'd8 || st == 4'd9 || (st == 4'd6 && mr))
         exp_ret = exp_ret + 16'd1;
      if (st == 4'd10)
         exp_ill = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      mem_ready = 1'b0;
      zero = 1'b0;
      exp_ret = 16'd0;
      exp_ill = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", {28'd0, state}, 32'd0);
      chk("rst_ctl", {18'd0, obs_ctl}, {18'd0, exp_ctl(4'd0, 1'b0, 1'b0)});
      chk("rst_retired", {16'd0, retired}, 32'd0);
      chk("rst_illegal", {31'd0, illegal}, 32'd0);
      rst_n = 1'b1;
   endtask

   initial begin
      do_reset();

      // Build up non-reset state, then abort a stalled load with async reset
      opcode = 7'b0110011;
      cyc(0, 1, 0); cyc(1, 1, 0); cyc(2, 1, 0); cyc(7, 1, 0);
      opcode = 7'b1111111;
      cyc(0, 1, 0); cyc(1, 1, 0); cyc(10, 1, 0);
      opcode = 7'b0000011;
      cyc(0, 1, 0); cyc(1, 1, 0); cyc(4, 1, 0);
      mem_ready = 1'b0;
      sb.push_back('{st: 4'd5, ctl: exp_ctl(4'd5, 1'b0, 1'b0), ret: exp_ret, ill: exp_ill});
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_state", {28'd0, state}, 32'd0);
      chk("arst_ctl", {18'd0, obs_ctl}, {18'd0, exp_ctl(4'd0, 1'b0, 1'b0)});
      chk("arst_retired", {16'd0, retired}, 32'd0);
      chk("arst_illegal", {31'd0, illegal}, 32'd0);
      do_reset();

      // Main instruction mix from clean reset
      opcode = 7'b0110011;
      cyc(0, 1, 0); cyc(1, 1, 0); cyc(2, 1, 0); cyc(7, 1, 0);
      opcode = 7'b0010011;
      cyc(0, 0, 0); cyc(0, 1, 0); cyc(1, 1, 0); cyc(3, 1, 0); cyc(7, 1, 0);
      opcode = 7'b0000011;
      cyc(0, 1, 0); cyc(1, 1, 0); cyc(4, 1, 0);
      cyc(5, 0, 0); cyc(5, 0, 0); cyc(5, 1, 0); cyc(8, 1, 0);
      opcode = 7'b0100011;
      cyc(0, 1, 0); cyc(1, 1, 0); cyc(4, 1, 0); cyc(6, 0, 0); cyc(6, 1, 0);
      opcode = 7'b1100011;
      cyc(0, 1, 0); cyc(1, 1, 0); cyc(9, 1, 1);
      cyc(0, 1, 0); cyc(1, 1, 0); cyc(9, 1, 0);
      opcode = 7'b1100110;
      cyc(0, 1, 0); cyc(1, 1, 0); cyc(10, 1, 0);
      opcode = 7'b0110011;
      cyc(0, 1, 0); cyc(1, 1, 0); cyc(2, 1, 0); cyc(7, 1, 0);
      cyc(0, 0, 0);

      // Counter wrap: 65535 R-type retires, then one store
      do_reset();
      opcode = 7'b0110011;
      mem_ready = 1'b1;
      repeat (4 * 65535) @(posedge clk);
      #1;
      chk("wrap_pre_state", {28'd0, state}, 32'd0);
      chk("wrap_pre_retired", {16'd0, retired}, 32'h0000_FFFF);
      exp_ret = 16'hFFFF;
      opcode = 7'b0100011;
      cyc(0, 1, 0); cyc(1, 1, 0); cyc(4, 1, 0); cyc(6, 1, 0);
      cyc(0, 0, 0);
      @(negedge clk);
      #1;
      chk("sb_drained", sb.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
